// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with single-cycle ops and iterative unsigned multiply
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       signal,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MULTU = 6'h19;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] acc_hi, acc_hi_n;
    logic [WIDTH-1:0] acc_lo, acc_lo_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0] out_n, hi_n;
    logic             zero_n, busy_n, done_n;

    logic [WIDTH-1:0] diff;
    logic             slt_bit;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;

    // Single-cycle result; SLT uses sign of difference corrected by signed overflow
    always_comb begin
        diff    = in0 - in1;
        slt_bit = diff[WIDTH-1] ^ ((in0[WIDTH-1] ^ in1[WIDTH-1]) & (diff[WIDTH-1] ^ in0[WIDTH-1]));
        alu_res = '0;
        case (signal)
            F_AND:   alu_res = in0 & in1;
            F_OR:    alu_res = in0 | in1;
            F_ADD:   alu_res = in0 + in1;
            F_SUB:   alu_res = diff;
            F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            F_SRL:   alu_res = in0 >> in1[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand into upper half, then shift {carry, acc_hi, acc_lo} right
    always_comb begin
        addend = acc_lo[0] ? mcand : '0;
        sum    = {1'b0, acc_hi} + {1'b0, addend};
        mul_hi = sum[WIDTH:1];
        mul_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        cnt_n    = cnt;
        out_n    = out;
        hi_n     = hi;
        zero_n   = zero;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (signal == F_MULTU) begin
                        mcand_n  = in0;
                        acc_lo_n = in1;
                        acc_hi_n = '0;
                        cnt_n    = '0;
                        busy_n   = 1'b1;
                        state_n  = MUL;
                    end else begin
                        out_n  = alu_res;
                        zero_n = (alu_res == '0);
                        done_n = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_hi_n = mul_hi;
                acc_lo_n = mul_lo;
                cnt_n    = cnt + 1'b1;
                busy_n   = 1'b1;
                if (cnt == LAST_ITER) begin
                    out_n   = mul_lo;
                    hi_n    = mul_hi;
                    zero_n  = (mul_lo == '0);
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            out    <= '0;
            hi     <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            cnt    <= cnt_n;
            out    <= out_n;
            hi     <= hi_n;
            zero   <= zero_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle
`timescale 1ns/1ps
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset, start, start8;
    logic [5:0]  signal, signal8;
    logic [31:0] in0, in1, out, hi;
    logic        zero, busy, done;
    logic [7:0]  in0_8, in1_8, out8, hi8;
    logic        zero8, busy8, done8;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_out, m_hi;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .signal(signal),
        .in0(in0), .in1(in1), .out(out), .hi(hi),
        .zero(zero), .busy(busy), .done(done)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signal(signal8),
        .in0(in0_8), .in1(in1_8), .out(out8), .hi(hi8),
        .zero(zero8), .busy(busy8), .done(done8)
    );

    // Reference: {hi, out} after an operation, from plain arithmetic
    function automatic logic [63:0] model(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h);
        logic [31:0] r;
        case (c)
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h02: r = a >> b[4:0];
            6'h19: return 64'(a) * 64'(b);
            default: r = 32'd0;
        endcase
        return {h, r};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corners [4];
        corners[0] = 32'h0; corners[1] = 32'hFFFFFFFF;
        corners[2] = 32'h80000000; corners[3] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        signal = c; in0 = a; in1 = b; start = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start8 = 1'b0;
        signal = 6'h0; in0 = 32'h0; in1 = 32'h0;
        signal8 = 6'h0; in0_8 = 8'h0; in1_8 = 8'h0;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({out, hi, zero, busy, done} !== {32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset32 out=%h hi=%h zero=%b busy=%b done=%b required 0 0 1 0 0", out, hi, zero, busy, done);
        end
        n_cmp++;
        if ({out8, hi8, zero8, busy8, done8} !== {8'h0, 8'h0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset8 out=%h hi=%h zero=%b busy=%b done=%b required 0 0 1 0 0", out8, hi8, zero8, busy8, done8);
        end
        m_out = 32'h0; m_hi = 32'h0;
    endtask

    task automatic test_add();
        issue(6'h20, 32'h7FFFFFFF, 32'h00000001);
        step();
        start = 1'b0;
        n_cmp++;
        if ({out, zero, done, busy} !== {32'h80000000, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL add out=%h zero=%b done=%b busy=%b required 80000000 0 1 0", out, zero, done, busy);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL add_single_pulse done=%b busy=%b required 0 0", done, busy);
        end
        m_out = 32'h80000000;
    endtask

    task automatic test_back_to_back();
        issue(6'h22, 32'd5, 32'd5);
        step();
        n_cmp++;
        if ({out, zero, done} !== {32'h0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_sub out=%h zero=%b done=%b required 0 1 1", out, zero, done);
        end
        issue(6'h2A, 32'hFFFFFFFF, 32'h00000001);
        step();
        n_cmp++;
        if ({out, zero, done} !== {32'h1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_slt_neg out=%h zero=%b done=%b required 1 0 1", out, zero, done);
        end
        issue(6'h2A, 32'h80000000, 32'h7FFFFFFF);
        step();
        start = 1'b0;
        n_cmp++;
        if ({out, zero, done} !== {32'h1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_slt_ext out=%h zero=%b done=%b required 1 0 1", out, zero, done);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_done_drop done=%b required 0", done);
        end
        m_out = 32'h1;
    endtask

    task automatic test_multu_ignore();
        issue(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 1; c <= 32; c++) begin
            step();
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || out !== m_out) begin
                n_bad++;
                $display("FAIL mul_busy cycle=%0d busy=%b done=%b out=%h required 1 0 %h", c, busy, done, out, m_out);
            end
            if (c == 10) issue(6'h20, 32'h1, 32'h2);
            else start = 1'b0;
        end
        step();
        n_cmp++;
        if ({done, busy, hi, out, zero} !== {1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_result done=%b busy=%b hi=%h out=%h zero=%b required 1 0 fffffffe 00000001 0", done, busy, hi, out, zero);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || out !== 32'h1) begin
            n_bad++;
            $display("FAIL mul_after done=%b out=%h required 0 00000001", done, out);
        end
        m_out = 32'h1; m_hi = 32'hFFFFFFFE;
    endtask

    task automatic test_multu_reset();
        issue(6'h19, 32'h12345678, 32'h9ABCDEF0);
        for (int c = 1; c <= 12; c++) begin
            step();
            start = 1'b0;
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mul_busy cycle=%0d busy=%b done=%b required 1 0", c, busy, done);
            end
            if (c == 12) reset = 1'b1;
        end
        step();
        reset = 1'b0;
        n_cmp++;
        if ({busy, out, hi, zero, done} !== {1'b0, 32'h0, 32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mul_state busy=%b out=%h hi=%h zero=%b done=%b required 0 0 0 1 0", busy, out, hi, zero, done);
        end
        for (int c = 0; c < 40; c++) begin
            step();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mul_no_done cycle=%0d done=%b busy=%b required 0 0", c, done, busy);
            end
        end
        m_out = 32'h0; m_hi = 32'h0;
    endtask

    task automatic test_width8();
        signal8 = 6'h19; in0_8 = 8'd200; in1_8 = 8'd200; start8 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start8 = 1'b0;
            n_cmp++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                n_bad++;
                $display("FAIL w8_busy cycle=%0d busy=%b done=%b required 1 0", c, busy8, done8);
            end
        end
        step();
        n_cmp++;
        if ({done8, busy8, hi8, out8} !== {1'b1, 1'b0, 8'h9C, 8'h40}) begin
            n_bad++;
            $display("FAIL w8_mul done=%b busy=%b hi=%h out=%h required 1 0 9c 40", done8, busy8, hi8, out8);
        end
        signal8 = 6'h02; in0_8 = 8'h80; in1_8 = 8'h07; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n_cmp++;
        if ({out8, zero8, done8, hi8} !== {8'h01, 1'b0, 1'b1, 8'h9C}) begin
            n_bad++;
            $display("FAIL w8_srl out=%h zero=%b done=%b hi=%h required 01 0 1 9c", out8, zero8, done8, hi8);
        end
    endtask

    task automatic test_illegal();
        int lat;
        issue(6'h19, 32'h80000000, 32'h00000002);
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_cmp++;
        if ({done, hi, out, zero} !== {1'b1, 32'h1, 32'h0, 1'b1} || lat != 33) begin
            n_bad++;
            $display("FAIL ill_pre_mul done=%b hi=%h out=%h zero=%b lat=%0d required 1 1 0 1 33", done, hi, out, zero, lat);
        end
        issue(6'h3F, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        start = 1'b0;
        n_cmp++;
        if ({out, zero, hi, done, busy} !== {32'h0, 1'b1, 32'h1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal out=%h zero=%b hi=%h done=%b busy=%b required 0 1 1 1 0", out, zero, hi, done, busy);
        end
        m_out = 32'h0; m_hi = 32'h1;
    endtask

    task automatic test_random();
        logic [5:0]  codes [7];
        logic [5:0]  c;
        logic [31:0] a, b;
        logic [63:0] exp;
        int          lat, exp_lat;
        codes[0] = 6'h24; codes[1] = 6'h25; codes[2] = 6'h20; codes[3] = 6'h22;
        codes[4] = 6'h2A; codes[5] = 6'h02; codes[6] = 6'h19;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 7) c = 6'($urandom);
            else c = codes[$urandom_range(0, 6)];
            a = pick();
            b = pick();
            exp     = model(c, a, b, m_hi);
            exp_lat = (c == 6'h19) ? 33 : 1;
            issue(c, a, b);
            step();
            start = 1'b0;
            lat = 1;
            while (done !== 1'b1 && lat < 40) begin
                if (busy === 1'b1 && $urandom_range(0, 1) == 1) issue(6'($urandom), $urandom, $urandom);
                else start = 1'b0;
                step();
                lat++;
            end
            start = 1'b0;
            n_cmp++;
            if (done !== 1'b1 || lat != exp_lat) begin
                n_bad++;
                $display("FAIL rnd_latency op=%h done=%b lat=%0d required 1 %0d", c, done, lat, exp_lat);
            end
            n_cmp++;
            if ({hi, out, zero, busy} !== {exp[63:32], exp[31:0], exp[31:0] == 32'h0, 1'b0}) begin
                n_bad++;
                $display("FAIL rnd_result op=%h a=%h b=%h hi=%h out=%h zero=%b busy=%b required %h %h %b 0",
                         c, a, b, hi, out, zero, busy, exp[63:32], exp[31:0], exp[31:0] == 32'h0);
            end
            m_hi  = exp[63:32];
            m_out = exp[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_multu_ignore();
        test_multu_reset();
        test_width8();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the 32-bit ripple ALU. It executes single-cycle integer operations selected by a 6-bit function code, plus an iterative unsigned multiply that produces a double-width product over WIDTH cycles. It sits between the register-file read stage and write-back, and uses a start/busy/done handshake so the controller can stall on multi-cycle operations.

## Interface
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in a cycle where busy=0.
- signal  in  6  function code, sampled with start.
- in0  in  WIDTH  operand A, sampled with start.
- in1  in  WIDTH  operand B, sampled with start.
- out  out  WIDTH  registered result; the low half of the product for MULTU.
- hi  out  WIDTH  registered high half of the product; written only by MULTU.
- zero  out  1  registered; 1 when out==0; updates together with out.
- busy  out  1  1 while a MULTU is in progress.
- done  out  1  one-cycle pulse; result valid in that cycle.

## Operation
- Function codes (MIPS funct):
  - AND 6'h24: in0 & in1.
  - OR 6'h25: in0 | in1.
  - ADD 6'h20: in0 + in1, mod 2^WIDTH, no overflow trap.
  - SUB 6'h22: in0 - in1, mod 2^WIDTH.
  - SLT 6'h2A: 1 if signed in0 < signed in1, else 0. Computed from the subtract sign XOR the signed overflow, so it is correct at the extremes.
  - SRL 6'h02: in0 >> in1[SHW-1:0], logical.
  - MULTU 6'h19: unsigned {hi,out} = in0 * in1.
- Any other code: out=0, zero=1, hi unchanged, done pulses as for a single-cycle op.
- FSM states:
  - IDLE: accepts start. A single-cycle op writes out/zero and stays in IDLE. MULTU latches the multiplicand and multiplier, clears the accumulator and counter, and goes to MUL.
  - MUL: one shift-add iteration per cycle. If the multiplier LSB is 1, add the multiplicand to the upper accumulator and keep the carry. Then shift {carry, acc_hi, multiplier} right by 1. Counter counts 0..WIDTH-1. On the last iteration, write hi=acc_hi and out=acc_lo, and return to IDLE.
- out, hi and zero hold their values between operations. Intermediate multiply state is internal and never appears on the outputs.
- start while busy=1 is ignored; operands are not resampled.
- Reset:
  - Returns the FSM to IDLE.
  - out=0, hi=0, zero=1, busy=0, done=0.
  - Clears the internal accumulator and counter.
  - A multiply interrupted by reset never asserts done.

## Timing
- Cycle 0 is the cycle in which start=1 and busy=0 are sampled.
- Single-cycle op: out and zero are valid and done=1 in cycle 1; busy stays 0.
  - Back-to-back starts give one result per cycle, and done stays high continuously.
- MULTU:
  - busy=1 in cycles 1..WIDTH.
  - Iterations happen at the clock edges ending cycles 1..WIDTH.
  - In cycle WIDTH+1: done=1, busy=0, {hi,out} valid.
  - Total latency is WIDTH+1 cycles. A new start is accepted in cycle WIDTH+1.
- done is never high for two consecutive cycles from a single request.
- busy and done are never high in the same cycle.
- Reset sampled in any cycle forces reset values in the following cycle, regardless of start.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> out=0x80000000, zero=0, done=1 in cycle 1, busy=0 throughout.
- WIDTH=32, SUB 5-5, then SLT 0xFFFFFFFF vs 0x00000001, then SLT 0x80000000 vs 0x7FFFFFFF on consecutive cycles -> out=0 with zero=1, then out=1, then out=1. done is high for 3 consecutive cycles.
- WIDTH=32, MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy in cycles 1..32. In cycle 33: hi=0xFFFFFFFE, out=0x00000001, done=1. A start with ADD issued in cycle 10 is ignored and out is unchanged until cycle 33.
- WIDTH=32, MULTU 0x12345678 * 0x9ABCDEF0 with reset asserted in cycle 12 -> cycle 13 shows busy=0, out=0, hi=0, zero=1. done is never asserted.
- WIDTH=8, MULTU 200*200 -> hi=0x9C, out=0x40, done in cycle 9. Then SRL in0=0x80, in1=0x07 -> out=0x01 in the next cycle.
- WIDTH=32, illegal code 6'h3F with in0=in1=0xFFFFFFFF after a MULTU that left hi=0x1 -> out=0, zero=1, hi=0x1, done=1 in cycle 1.
